// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline stage register with a 2-entry skid buffer, flush/bubble
// handling and saturating stall/flush counters. in_ready is driven from a flop only.
module pipe_stage_skid #(
    parameter int CTRL_W     = 16,
    parameter int DATA_W     = 160,
    parameter int CLEAR_DATA = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam bit CLR_D = (CLEAR_DATA != 0);

    logic              r_main_vld;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic              r_skid_vld;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic              w_in_fire;
    logic              w_out_fire;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign in_ready   = !r_skid_vld;
    assign w_in_fire  = in_valid && !r_skid_vld && !clr;
    assign w_out_fire = r_main_vld && out_ready;

    assign out_valid  = r_main_vld;
    assign out_ctrl   = r_main_ctrl;
    assign out_data   = r_main_data;
    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;

    // Control is cleared on every transition to an invalid entry, so out_ctrl is
    // already zero whenever out_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_vld  <= 1'b0;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_vld  <= 1'b0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (clr) begin
            r_main_vld  <= 1'b0;
            r_main_ctrl <= '0;
            r_main_data <= CLR_D ? '0 : r_main_data;
            r_skid_vld  <= 1'b0;
            r_skid_ctrl <= '0;
            r_skid_data <= CLR_D ? '0 : r_skid_data;
        end else if (!r_main_vld) begin
            if (w_in_fire) begin
                r_main_vld  <= 1'b1;
                r_main_ctrl <= in_ctrl;
                r_main_data <= in_data;
            end
        end else if (!r_skid_vld) begin
            if (w_in_fire) begin
                if (w_out_fire) begin
                    r_main_ctrl <= in_ctrl;
                    r_main_data <= in_data;
                end else begin
                    r_skid_vld  <= 1'b1;
                    r_skid_ctrl <= in_ctrl;
                    r_skid_data <= in_data;
                end
            end else if (w_out_fire) begin
                r_main_vld  <= 1'b0;
                r_main_ctrl <= '0;
                r_main_data <= CLR_D ? '0 : r_main_data;
            end
        end else if (w_out_fire) begin
            r_main_ctrl <= r_skid_ctrl;
            r_main_data <= r_skid_data;
            r_skid_vld  <= 1'b0;
            r_skid_ctrl <= '0;
            r_skid_data <= CLR_D ? '0 : r_skid_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (r_main_vld && !out_ready)
                r_stall_cnt <= sat_inc(r_stall_cnt);
            if (clr)
                r_flush_cnt <= sat_inc(r_flush_cnt);
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed tables, hand sequences and a queue-based
// reference model under random traffic; a second narrow instance covers CLEAR_DATA=0 and CNT_W=4.
module tb_pipe_stage_skid;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    logic         in_valid = 1'b0, in_ready, clr = 1'b0, out_valid, out_ready = 1'b0;
    logic [15:0]  in_ctrl = '0, out_ctrl, stall_cnt, flush_cnt;
    logic [159:0] in_data = '0, out_data;

    logic         b_in_valid = 1'b0, b_in_ready, b_clr = 1'b0, b_out_valid, b_out_ready = 1'b0;
    logic [7:0]   b_in_ctrl = '0, b_out_ctrl;
    logic [15:0]  b_in_data = '0, b_out_data;
    logic [3:0]   b_stall_cnt, b_flush_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.CTRL_W(16), .DATA_W(160), .CLEAR_DATA(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .clr(clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stage_skid #(.CTRL_W(8), .DATA_W(16), .CLEAR_DATA(0), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
        .clr(b_clr),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    // Reference model: the stage is a FIFO of at most two words.
    typedef struct {
        logic [15:0]  c;
        logic [159:0] d;
    } word_t;

    word_t q[$];
    int    m_stall = 0;
    int    m_flush = 0;

    typedef struct {
        logic        iv;
        logic [15:0] ic;
        logic        ordy;
        logic        iclr;
        logic        ev;
        logic [15:0] ec;
        logic        eir;
        int          estall;
        int          eflush;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [159:0] dat(input logic [15:0] c);
        return {c, 128'hABCD, c};
    endfunction

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_step();
        bit    ov, inf, of;
        word_t w;
        ov = (q.size() > 0);
        if (ov && !out_ready && m_stall < 65535) m_stall++;
        if (clr && m_flush < 65535) m_flush++;
        if (clr) begin
            q.delete();
        end else begin
            inf = in_valid && (q.size() < 2);
            of  = ov && out_ready;
            if (of) void'(q.pop_front());
            if (inf) begin
                w.c = in_ctrl;
                w.d = in_data;
                q.push_back(w);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic chk_model(input string nm);
        logic [15:0]  ec;
        logic [159:0] ed;
        ec = (q.size() > 0) ? q[0].c : 16'h0;
        ed = (q.size() > 0) ? q[0].d : 160'h0;
        chk({nm, ".valid"}, out_valid, q.size() > 0);
        chk({nm, ".ctrl"}, out_ctrl, ec);
        chk({nm, ".data"}, out_data, ed);
        chk({nm, ".in_ready"}, in_ready, q.size() < 2);
        chk({nm, ".stall"}, stall_cnt, m_stall);
        chk({nm, ".flush"}, flush_cnt, m_flush);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Test 3 (push A/B/C against a stalled consumer) and test 4 (flush from TWO).
        tbl[0] = '{1'b1, 16'h000A, 1'b0, 1'b0, 1'b1, 16'h000A, 1'b1, 0, 0};
        tbl[1] = '{1'b1, 16'h000B, 1'b0, 1'b0, 1'b1, 16'h000A, 1'b0, 1, 0};
        tbl[2] = '{1'b1, 16'h000C, 1'b0, 1'b0, 1'b1, 16'h000A, 1'b0, 2, 0};
        tbl[3] = '{1'b1, 16'h000C, 1'b1, 1'b0, 1'b1, 16'h000B, 1'b1, 2, 0};
        tbl[4] = '{1'b1, 16'h000C, 1'b1, 1'b0, 1'b1, 16'h000C, 1'b1, 2, 0};
        tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 2, 0};
        tbl[6] = '{1'b1, 16'h0011, 1'b0, 1'b0, 1'b1, 16'h0011, 1'b1, 2, 0};
        tbl[7] = '{1'b1, 16'h0022, 1'b0, 1'b0, 1'b1, 16'h0011, 1'b0, 3, 0};
        tbl[8] = '{1'b1, 16'h0033, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 4, 1};
        tbl[9] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 4, 1};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk_model("reset");
        chk("reset.valid_const", out_valid, 1'b0);
        chk("reset.in_ready_const", in_ready, 1'b1);

        // Stream of 8 words at full rate
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_ctrl  = 16'(i);
            in_data  = 160'h100 + 160'(i);
            cycle();
            chk("stream.valid", out_valid, 1'b1);
            chk("stream.ctrl", out_ctrl, i);
            chk("stream.data", out_data, 160'h100 + 160'(i));
            chk("stream.in_ready", in_ready, 1'b1);
        end
        in_valid = 1'b0;
        cycle();
        chk("stream.drain_valid", out_valid, 1'b0);
        chk("stream.stall", stall_cnt, 0);

        for (int i = 0; i < 10; i++) begin
            in_valid  = tbl[i].iv;
            in_ctrl   = tbl[i].ic;
            in_data   = dat(tbl[i].ic);
            out_ready = tbl[i].ordy;
            clr       = tbl[i].iclr;
            cycle();
            chk($sformatf("tbl%0d.valid", i), out_valid, tbl[i].ev);
            chk($sformatf("tbl%0d.ctrl", i), out_ctrl, tbl[i].ec);
            chk($sformatf("tbl%0d.data", i), out_data, tbl[i].ev ? dat(tbl[i].ec) : 160'h0);
            chk($sformatf("tbl%0d.in_ready", i), in_ready, tbl[i].eir);
            chk($sformatf("tbl%0d.stall", i), stall_cnt, tbl[i].estall);
            chk($sformatf("tbl%0d.flush", i), flush_cnt, tbl[i].eflush);
        end
        clr = 1'b0;

        // Random traffic against the FIFO model
        for (int n = 0; n < 2000; n++) begin
            in_valid  = ($urandom % 4) != 0;
            in_ctrl   = 16'($urandom);
            in_data   = {$urandom, $urandom, $urandom, $urandom, $urandom};
            out_ready = (n % 200 < 100) ? (($urandom % 3) != 0) : (($urandom % 3) == 0);
            clr       = ($urandom % 20) == 0;
            cycle();
            chk_model($sformatf("rand%0d", n));
        end
        in_valid = 1'b0;
        clr      = 1'b0;

        // CLEAR_DATA=0: data holds after the word leaves and across a flush
        b_in_valid = 1'b1; b_in_ctrl = 8'h5A; b_in_data = 16'hDEAD; b_out_ready = 1'b0;
        cycle();
        chk("nc.load_valid", b_out_valid, 1'b1);
        chk("nc.load_data", b_out_data, 16'hDEAD);
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        cycle();
        chk("nc.drain_valid", b_out_valid, 1'b0);
        chk("nc.drain_ctrl", b_out_ctrl, 8'h00);
        chk("nc.drain_data", b_out_data, 16'hDEAD);
        b_in_valid = 1'b1; b_in_ctrl = 8'h3C; b_in_data = 16'hBEEF; b_out_ready = 1'b0;
        cycle();
        b_in_ctrl = 8'h77; b_in_data = 16'h1234; b_clr = 1'b1;
        cycle();
        chk("nc.flush_valid", b_out_valid, 1'b0);
        chk("nc.flush_ctrl", b_out_ctrl, 8'h00);
        chk("nc.flush_data", b_out_data, 16'hBEEF);
        chk("nc.flush_in_ready", b_in_ready, 1'b1);
        b_in_valid = 1'b0;
        repeat (20) cycle();
        chk("nc.flush_sat", b_flush_cnt, 4'd15);
        b_clr = 1'b0;

        // Pulse reset between edges, then stall-counter saturation with CNT_W=4
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        cycle();
        chk("sat.reset_stall", b_stall_cnt, 4'd0);
        chk("sat.reset_flush", b_flush_cnt, 4'd0);
        b_in_valid = 1'b1; b_in_ctrl = 8'h42; b_in_data = 16'h4242; b_out_ready = 1'b0;
        cycle();
        b_in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            chk($sformatf("sat.stall%0d", k), b_stall_cnt, (k > 15) ? 15 : k);
            chk($sformatf("sat.valid%0d", k), b_out_valid, 1'b1);
        end

        // Asynchronous reset mid-hold, checked before the next rising edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("async.valid", b_out_valid, 1'b0);
        chk("async.ctrl", b_out_ctrl, 8'h00);
        chk("async.data", b_out_data, 16'h0000);
        chk("async.in_ready", b_in_ready, 1'b1);
        chk("async.stall", b_stall_cnt, 4'd0);
        chk("async.flush", b_flush_cnt, 4'd0);
        chk("async.main_valid", out_valid, 1'b0);
        chk("async.main_ctrl", out_ctrl, 16'h0);
        #10;
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Generic, parametrised pipeline stage register that replaces the fixed-field stage registers (e.g. ID/EX) in the RV32 pipeline. It carries a control bundle and a data bundle with a valid/ready handshake. A 2-entry skid buffer keeps full throughput while in_ready stays registered. It provides synchronous flush, bubble insertion with zeroed control, and saturating stall/flush performance counters.

Parameters:
CTRL_W, 16, width of control bundle (regwrite, resultsrc, memwrite, jump, branch, alucontrol, alusrc, ...); zeroed on bubble/flush.
DATA_W, 160, width of data bundle (operands, pc, imm, register indices, pc+4, ...).
CLEAR_DATA, 1, 1 = data bundle zeroed on flush/bubble; 0 = data bundle holds its last value.
CNT_W, 16, width of each performance counter.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream has a stage word
in_ready  output  1  stage can accept; equals !skid_valid (register-driven, no combinational path from out_ready)
in_ctrl  input  CTRL_W  upstream control bundle
in_data  input  DATA_W  upstream data bundle
clr  input  1  synchronous flush (branch mispredict / load-use bubble)
out_valid  output  1  main entry valid
out_ready  input  1  downstream accepts
out_ctrl  output  CTRL_W  main entry control; all-zero whenever out_valid=0
out_data  output  DATA_W  main entry data
stall_cnt  output  CNT_W  cycles with out_valid && !out_ready, saturating
flush_cnt  output  CNT_W  cycles with clr=1, saturating

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, skid_valid=0, out_ctrl=0, out_data=0, skid contents=0, in_ready=1, stall_cnt=0, flush_cnt=0. Deassertion is sampled synchronously by the next clock edge.
- in_fire = in_valid && in_ready && !clr. out_fire = out_valid && out_ready.
- Occupancy states:
  - EMPTY: main=0, skid=0.
  - ONE: main=1, skid=0.
  - TWO: main=1, skid=1.
- EMPTY: in_fire -> main<=in, go to ONE. Otherwise stay.
- ONE:
  - in_fire && out_fire -> main<=in, stay in ONE.
  - out_fire only -> go to EMPTY; main ctrl<=0 (and data<=0 if CLEAR_DATA).
  - in_fire only -> skid<=in, go to TWO.
  - Neither -> hold.
- TWO: in_ready=0, so no input is accepted.
  - out_fire -> main<=skid, skid cleared, go to ONE.
  - Otherwise hold.
- Latency: 1 cycle from in_fire in EMPTY to out_valid=1. Sustained throughput is 1 word/cycle with out_ready=1.
- Ordering: strict FIFO order. The skid word always leaves after the main word. No word is duplicated or dropped except by clr.
- clr (priority over all transfers):
  - Next state is EMPTY.
  - main and skid ctrl<=0; data<=0 if CLEAR_DATA=1, otherwise held.
  - The input word in the same cycle is discarded. Upstream sees the same flush.
  - out_fire in the same cycle still completes downstream (out_* are stable that cycle). The entry is dropped from the stage regardless.
- Bubble semantics: out_ctrl=0 whenever out_valid=0, so downstream hazard/forwarding logic sees a NOP even if it ignores valid.
- stall_cnt: +1 each cycle with out_valid && !out_ready; saturates at 2^CNT_W-1. Unaffected by clr.
- flush_cnt: +1 each cycle with clr=1; saturates at 2^CNT_W-1.
- Reset mid-transfer: all state clears immediately. Any in-flight words are lost.
- Widths: ctrl and data registers are exactly CTRL_W/DATA_W. There is no sign or zero extension inside the block.

Test Plan:
1. Reset, then idle -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1, both counters 0.
2. Stream 8 words (ctrl=i, data=0x100+i), out_ready=1 -> word i appears the cycle after acceptance. out_data sequence is 0x100..0x107 back-to-back. in_ready stays 1. stall_cnt=0.
3. out_ready=0 while pushing ctrl=0xA/0xB/0xC -> 0xA held at output, 0xB goes to skid, in_ready=0 on the next cycle, 0xC held upstream. Release out_ready -> output order A, B, C. stall_cnt equals the number of held cycles.
4. State TWO, assert clr for 1 cycle with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, out_data=0 (CLEAR_DATA=1), in_ready=1. The input word is not seen. flush_cnt=1.
5. CLEAR_DATA=0, ONE state with data=0xDEAD, out_fire with no new input -> out_valid=0, out_ctrl=0, out_data=0xDEAD.
6. CNT_W=4, out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays at 15. Assert rst_n=0 mid-hold -> everything returns to 0 without waiting for a clock edge.
